// File: rtl/sound_pkg.sv
// Shared definitions for the melody generator: note codes, the melody table and
// the pitch half-period function.
package sound_pkg;

    typedef logic [3:0] note_t;

    localparam int HP_W      = 17;
    localparam int IDX_W     = 4;
    localparam int TABLE_LEN = 16;

    localparam note_t NOTE_REST = 4'd0;
    localparam note_t NOTE_C4   = 4'd1;
    localparam note_t NOTE_D4   = 4'd2;
    localparam note_t NOTE_E4   = 4'd3;
    localparam note_t NOTE_F4   = 4'd4;
    localparam note_t NOTE_G4   = 4'd5;
    localparam note_t NOTE_A4   = 4'd6;
    localparam note_t NOTE_B4   = 4'd7;
    localparam note_t NOTE_C5   = 4'd8;

    localparam note_t MELODY [0:TABLE_LEN-1] = '{
        NOTE_C4, NOTE_D4, NOTE_E4, NOTE_F4, NOTE_G4, NOTE_G4, NOTE_REST, NOTE_A4,
        NOTE_A4, NOTE_A4, NOTE_A4, NOTE_G4, NOTE_REST, NOTE_F4, NOTE_F4, NOTE_E4
    };

    function automatic logic is_rest_code(input note_t code);
        is_rest_code = (code == NOTE_REST) || (code > NOTE_C5);
    endfunction

    // Frequencies are held in milli-hertz so round(clk/(2f)) stays in integer math.
    function automatic logic [HP_W-1:0] hp_of(input longint clk_hz, input note_t code);
        longint f_mhz;
        longint hp;
        case (code)
            NOTE_C4: f_mhz = 64'd261626;
            NOTE_D4: f_mhz = 64'd293665;
            NOTE_E4: f_mhz = 64'd329628;
            NOTE_F4: f_mhz = 64'd349228;
            NOTE_G4: f_mhz = 64'd391995;
            NOTE_A4: f_mhz = 64'd440000;
            NOTE_B4: f_mhz = 64'd493883;
            NOTE_C5: f_mhz = 64'd523251;
            default: f_mhz = 64'd0;
        endcase
        if (f_mhz == 64'd0) begin
            hp = 64'd0;
        end else begin
            hp = (clk_hz * 64'd1000 + f_mhz) / (64'd2 * f_mhz);
        end
        hp_of = hp[HP_W-1:0];
    endfunction

endpackage

// File: rtl/sound_melody_if.sv
// Lookup bus between the melody sequencer (master) and the note ROM (slave).
interface sound_melody_if;
    import sound_pkg::*;

    logic [IDX_W-1:0] idx;
    logic [HP_W-1:0]  hp;
    logic             is_rest;

    modport master (output idx, input hp, is_rest);
    modport slave  (input idx, output hp, is_rest);

endinterface

// File: rtl/sound_note_rom.sv
// Combinational note lookup: melody index -> note code -> half-period in clocks.
module sound_note_rom
    import sound_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    sound_melody_if.slave bus
);

    logic [HP_W-1:0] hp_by_code [TABLE_LEN];
    note_t           code_w;

    generate
        for (genvar gi = 0; gi < TABLE_LEN; gi++) begin : g_hp
            assign hp_by_code[gi] = hp_of(CLK_HZ, note_t'(gi));
        end
    endgenerate

    assign code_w      = MELODY[bus.idx];
    assign bus.hp      = hp_by_code[code_w];
    assign bus.is_rest = is_rest_code(code_w);

endmodule

// File: rtl/sound_melody.sv
// Autonomous fixed-melody square-wave generator.
// Define SOUND_LOOP_EN to repeat the melody; otherwise it plays once and goes silent.
module sound_melody
    import sound_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int NOTE_CYCLES = 12_500_000,
    parameter int NUM_NOTES   = 16
) (
    input  logic iCLK,
    input  logic iRST_N,
    output logic oSOUND
);

    localparam int                DUR_W      = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;
    localparam logic [DUR_W-1:0]  DUR_LAST   = DUR_W'(NOTE_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_NOTES - 1);
    localparam logic [HP_W-1:0]   HP_FIRST   = hp_of(CLK_HZ, MELODY[0]);
    localparam logic              REST_FIRST = is_rest_code(MELODY[0]);

    logic [DUR_W-1:0] dur_q,  dur_d;
    logic [IDX_W-1:0] idx_q,  idx_d;
    logic [HP_W-1:0]  tone_q, tone_d;
    logic [HP_W-1:0]  hp_q,   hp_d;
    logic             rest_q, rest_d;
    logic             sound_q, sound_d;
    logic             done_q, done_d;
    logic             note_end;

    sound_melody_if rom_bus ();

    sound_note_rom #(.CLK_HZ(CLK_HZ)) u_rom (.bus(rom_bus.slave));

    // Look up the next index so hp_q/rest_q describe the note starting this edge.
    assign rom_bus.idx = idx_d;
    assign hp_d        = rom_bus.hp;
    assign rest_d      = rom_bus.is_rest;
    assign note_end    = (dur_q == DUR_LAST);

    always_comb begin
        dur_d   = dur_q;
        idx_d   = idx_q;
        done_d  = done_q;
        tone_d  = tone_q;
        sound_d = sound_q;
        if (!done_q) begin
            if (note_end) begin
                // Note change wins over a coincident toggle: restart low and phase-aligned.
                dur_d   = '0;
                tone_d  = '0;
                sound_d = 1'b0;
                if (idx_q == IDX_LAST) begin
`ifdef SOUND_LOOP_EN
                    idx_d = '0;
`else
                    done_d = 1'b1;
`endif
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end else begin
                dur_d = dur_q + DUR_W'(1);
                if (rest_q) begin
                    tone_d  = '0;
                    sound_d = 1'b0;
                end else if (tone_q == hp_q - HP_W'(1)) begin
                    tone_d  = '0;
                    sound_d = ~sound_q;
                end else begin
                    tone_d = tone_q + HP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            dur_q   <= '0;
            idx_q   <= '0;
            tone_q  <= '0;
            hp_q    <= HP_FIRST;
            rest_q  <= REST_FIRST;
            sound_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            dur_q   <= dur_d;
            idx_q   <= idx_d;
            tone_q  <= tone_d;
            hp_q    <= hp_d;
            rest_q  <= rest_d;
            sound_q <= sound_d;
            done_q  <= done_d;
        end
    end

    assign oSOUND = sound_q;

endmodule

// File: tb/tb_sound_melody.sv
// Directed bench for sound_melody: scaled clock (100 kHz pitch base, 1000-cycle notes)
// plus a full-rate note ROM lookup check.
module tb_sound_melody;
    import sound_pkg::*;

    localparam int TB_CLK_HZ = 100_000;
    localparam int TB_NOTE   = 1000;

    logic iCLK   = 1'b0;
    logic iRST_N = 1'b0;
    logic oSOUND;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    // Half-periods at 50 MHz per melody index; 0 marks a rest entry.
    int exp_hp50 [16] = '{95556, 85131, 75843, 71586, 63776, 63776, 0, 56818,
                          56818, 56818, 56818, 63776, 0, 71586, 71586, 75843};

    always #10 iCLK = ~iCLK;

    sound_melody #(
        .CLK_HZ      (TB_CLK_HZ),
        .NOTE_CYCLES (TB_NOTE),
        .NUM_NOTES   (16)
    ) dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .oSOUND (oSOUND)
    );

    sound_melody_if rom_if ();
    sound_note_rom #(.CLK_HZ(50_000_000)) u_rom50 (.bus(rom_if.slave));

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("[TB] ok   %s: %0d (cycle %0d)", tag, got, cyc);
        end
    endtask

    // Advance to the given edge count since reset release, then sample 1 time unit later.
    task automatic adv_to(input int t);
        while (cyc < t) begin
            @(posedge iCLK);
            cyc++;
        end
        #1;
    endtask

    task automatic scan_high(input int t_end, output logic seen);
        seen = oSOUND;
        while (cyc < t_end) begin
            @(posedge iCLK);
            cyc++;
            #1;
            seen = seen | oSOUND;
        end
    endtask

    task automatic release_rst();
        @(negedge iCLK);
        iRST_N = 1'b1;
        cyc    = 0;
    endtask

    initial begin
        logic seen;

        for (int i = 0; i < 16; i++) begin
            rom_if.idx = 4'(i);
            #1;
            if (exp_hp50[i] == 0)
                chk($sformatf("rom50_rest[%0d]", i), int'(rom_if.is_rest), 1);
            else
                chk($sformatf("rom50_hp[%0d]", i), int'(rom_if.hp), exp_hp50[i]);
        end

        for (int i = 0; i < 5; i++) begin
            @(negedge iCLK);
            chk("reset_hold", int'(oSOUND), 0);
        end
        release_rst();

        adv_to(190);   chk("c4_pre_rise", int'(oSOUND), 0);
        adv_to(191);   chk("c4_rise",     int'(oSOUND), 1);
        adv_to(382);   chk("c4_fall",     int'(oSOUND), 0);
        adv_to(573);   chk("c4_rise2",    int'(oSOUND), 1);
        adv_to(999);   chk("c4_last",     int'(oSOUND), 1);
        adv_to(1000);  chk("note1_start", int'(oSOUND), 0);
        adv_to(1169);  chk("d4_pre_rise", int'(oSOUND), 0);
        adv_to(1170);  chk("d4_rise",     int'(oSOUND), 1);
        adv_to(2152);  chk("e4_rise",     int'(oSOUND), 1);

        // Asynchronous reset in the middle of note 2, between clock edges.
        iRST_N = 1'b0;
        #1;
        chk("midnote_rst", int'(oSOUND), 0);
        repeat (3) @(posedge iCLK);
        #1;
        chk("rst_held", int'(oSOUND), 0);
        release_rst();

        adv_to(190);   chk("re_c4_pre",   int'(oSOUND), 0);
        adv_to(191);   chk("re_c4_rise",  int'(oSOUND), 1);
        adv_to(1000);  chk("re_note1",    int'(oSOUND), 0);
        adv_to(1170);  chk("re_d4_rise",  int'(oSOUND), 1);
        adv_to(5999);  chk("g4_last",     int'(oSOUND), 1);
        adv_to(6000);
        scan_high(6999, seen);
        chk("rest_note6_silent", int'(seen), 0);
        adv_to(7113);  chk("a4_pre_rise", int'(oSOUND), 0);
        adv_to(7114);  chk("a4_rise",     int'(oSOUND), 1);
        adv_to(7228);  chk("a4_fall",     int'(oSOUND), 0);
        adv_to(15152); chk("e4_last_rise", int'(oSOUND), 1);
        adv_to(16000); chk("melody_end",  int'(oSOUND), 0);
`ifdef SOUND_LOOP_EN
        adv_to(16190); chk("loop_c4_pre",  int'(oSOUND), 0);
        adv_to(16191); chk("loop_c4_rise", int'(oSOUND), 1);
        adv_to(16382); chk("loop_c4_fall", int'(oSOUND), 0);
        adv_to(17000); chk("loop_note1",   int'(oSOUND), 0);
        adv_to(17170); chk("loop_d4_rise", int'(oSOUND), 1);
`else
        scan_high(18000, seen);
        chk("finished_silent", int'(seen), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
